// File: rtl/btb_update_ctrl.sv
// Read-modify-write controller for BTB set storage: applies resolved-branch updates and sequences full flushes.
// Latency: accept at T, storage write at T+3, ready again at T+4; miss-not-taken completes at T+2 with no write.
// Backpressure: upd_ready is high only in IDLE; a flush takes 8 cycles and holds upd_ready low throughout.
module btb_update_ctrl #(
    parameter int NUM_SETS = 8,
    parameter int SET_W    = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [31:0]                 upd_pc,
    input  logic [31:0]                 upd_target,
    input  logic                        upd_taken,
    input  logic                        flush,
    output logic [$clog2(NUM_SETS)-1:0] update_index,
    input  logic [SET_W-1:0]            update_set,
    output logic [$clog2(NUM_SETS)-1:0] write_index,
    output logic [SET_W-1:0]            write_set,
    output logic                        write_enable,
    output logic                        upd_done,
    output logic                        upd_hit
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MODIFY,
        WRITE,
        FLUSH
    } state_t;

    state_t            state, state_n;
    logic [31:2]       pc_q;
    logic [31:0]       tgt_q;
    logic              taken_q;
    logic [SET_W-1:0]  set_q;
    logic [SET_W-1:0]  wr_set_q;
    logic              hit_q;
    logic [IDX_W-1:0]  flush_cnt;

    logic [63:0]       w0, w1, new_w0, new_w1;
    logic [TAG_W-1:0]  tag;
    logic              hit0, hit1, hit_c, need_wr, lru_new, victim;
    logic              unused_pc_bits;

    assign unused_pc_bits = ^upd_pc[1:0];

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            ctr_next = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        else
            ctr_next = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

    // Set modification: way layout {valid, tag[26:0], target[31:0], ctr[1:0], aux[1:0]}
    always_comb begin
        w0      = set_q[63:0];
        w1      = set_q[127:64];
        tag     = pc_q[31:IDX_W+2];
        hit0    = w0[63] && (w0[62:36] == tag);
        hit1    = w1[63] && (w1[62:36] == tag);
        hit_c   = hit0 || hit1;
        new_w0  = w0;
        new_w1  = w1;
        lru_new = w0[1];
        need_wr = 1'b0;
        victim  = 1'b0;
        if (hit0) begin
            new_w0[3:2] = ctr_next(w0[3:2], taken_q);
            if (taken_q)
                new_w0[35:4] = tgt_q;
            lru_new = 1'b1;
            need_wr = 1'b1;
        end else if (hit1) begin
            new_w1[3:2] = ctr_next(w1[3:2], taken_q);
            if (taken_q)
                new_w1[35:4] = tgt_q;
            lru_new = 1'b0;
            need_wr = 1'b1;
        end else if (taken_q) begin
            if (!w0[63])
                victim = 1'b0;
            else if (!w1[63])
                victim = 1'b1;
            else
                victim = w0[1];
            if (victim)
                new_w1 = {1'b1, tag, tgt_q, 2'b10, 2'b00};
            else
                new_w0 = {1'b1, tag, tgt_q, 2'b10, 2'b00};
            lru_new = ~victim;
            need_wr = 1'b1;
        end
        new_w0[1:0] = {lru_new, 1'b0};
        new_w1[1:0] = 2'b00;
    end

    always_comb begin
        state_n      = state;
        upd_ready    = 1'b0;
        write_enable = 1'b0;
        write_index  = '0;
        write_set    = '0;
        upd_done     = 1'b0;
        upd_hit      = 1'b0;
        case (state)
            IDLE: begin
                upd_ready = 1'b1;
                if (flush)
                    state_n = FLUSH;
                else if (upd_valid)
                    state_n = LOOKUP;
            end
            LOOKUP: state_n = MODIFY;
            MODIFY: begin
                if (need_wr) begin
                    state_n = WRITE;
                end else begin
                    state_n  = IDLE;
                    upd_done = 1'b1;
                end
            end
            WRITE: begin
                write_enable = 1'b1;
                write_index  = pc_q[IDX_W+1:2];
                write_set    = wr_set_q;
                upd_done     = 1'b1;
                upd_hit      = hit_q;
                state_n      = IDLE;
            end
            FLUSH: begin
                write_enable = 1'b1;
                write_index  = flush_cnt;
                if (flush_cnt == IDX_W'(NUM_SETS - 1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset overrides everything so an in-flight operation never reaches storage
        if (rst) begin
            upd_ready    = 1'b0;
            write_enable = 1'b0;
            write_index  = '0;
            write_set    = '0;
            upd_done     = 1'b0;
            upd_hit      = 1'b0;
        end
    end

    assign update_index = pc_q[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= '0;
            tgt_q     <= '0;
            taken_q   <= 1'b0;
            set_q     <= '0;
            wr_set_q  <= '0;
            hit_q     <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (flush) begin
                        flush_cnt <= '0;
                    end else if (upd_valid) begin
                        pc_q    <= upd_pc[31:2];
                        tgt_q   <= upd_target;
                        taken_q <= upd_taken;
                    end
                end
                LOOKUP: set_q <= update_set;
                MODIFY: begin
                    wr_set_q <= {new_w1, new_w0};
                    hit_q    <= hit_c;
                end
                FLUSH: flush_cnt <= flush_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a behavioural set store feeds the read port and absorbs writes.
// Drivers push hand-computed writes/completions with their due cycle; a negedge monitor pops and compares.
module tb_btb_update_ctrl;
    logic         clk;
    logic         rst;
    logic         upd_valid;
    logic         upd_ready;
    logic [31:0]  upd_pc;
    logic [31:0]  upd_target;
    logic         upd_taken;
    logic         flush;
    logic [2:0]   update_index;
    logic [127:0] update_set;
    logic [2:0]   write_index;
    logic [127:0] write_set;
    logic         write_enable;
    logic         upd_done;
    logic         upd_hit;

    btb_update_ctrl #(.NUM_SETS(8), .SET_W(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .flush        (flush),
        .update_index (update_index),
        .update_set   (update_set),
        .write_index  (write_index),
        .write_set    (write_set),
        .write_enable (write_enable),
        .upd_done     (upd_done),
        .upd_hit      (upd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] mem [8];
    assign update_set = mem[update_index];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (write_enable) begin
            mem[write_index] <= write_set;
        end
    end

    typedef struct packed {
        logic [2:0]   idx;
        logic [127:0] set;
        int           cyc;
    } wr_t;
    typedef struct packed {
        logic hit;
        int   cyc;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    int  n_cmp;
    int  n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] way(input logic v, input logic [26:0] tg, input logic [31:0] tgt,
                                        input logic [1:0] ctr, input logic [1:0] aux);
        way = {v, tg, tgt, ctr, aux};
    endfunction

    always @(negedge clk) begin
        if (write_enable) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got write_enable=1 idx=%0d at cycle %0d, required none", write_index, cyc);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("write_index", 128'(write_index), 128'(e.idx));
                check("write_set", write_set, e.set);
                check("write_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
        if (upd_done) begin
            if (dn_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got upd_done=1 at cycle %0d, required none", cyc);
            end else begin
                dn_t d;
                d = dn_q.pop_front();
                check("upd_hit", 128'(upd_hit), 128'(d.hit));
                check("done_cycle", 128'(cyc), 128'(d.cyc));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!upd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got upd_ready=0 after 50 cycles, required 1");
        end
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                          input logic wr, input logic [127:0] eset, input logic ehit);
        wait_ready();
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        upd_valid  = 1'b1;
        if (wr) begin
            wr_q.push_back('{idx: pc[4:2], set: eset, cyc: cyc + 3});
            dn_q.push_back('{hit: ehit, cyc: cyc + 3});
        end else begin
            dn_q.push_back('{hit: 1'b0, cyc: cyc + 2});
        end
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input logic exp_ready);
        check("rst_upd_ready", 128'(upd_ready), 128'(exp_ready));
        check("rst_write_enable", 128'(write_enable), 128'(0));
        check("rst_write_index", 128'(write_index), 128'(0));
        check("rst_write_set", write_set, 128'(0));
        check("rst_update_index", 128'(update_index), 128'(0));
        check("rst_upd_done", 128'(upd_done), 128'(0));
        check("rst_upd_hit", 128'(upd_hit), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        rst        = 1'b1;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_target = '0;
        upd_taken  = 1'b0;
        flush      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs(1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 128'(upd_ready), 128'(1));

        // Allocate into empty set 1, then train the same entry
        do_upd(32'h0000_1044, 32'h2000, 1'b1, 1'b1, {64'h0, way(1, 27'h82, 32'h2000, 2'd2, 2'b10)}, 1'b0);
        do_upd(32'h0000_1044, 32'h2000, 1'b1, 1'b1, {64'h0, way(1, 27'h82, 32'h2000, 2'd3, 2'b10)}, 1'b1);
        do_upd(32'h0000_1044, 32'h2000, 1'b1, 1'b1, {64'h0, way(1, 27'h82, 32'h2000, 2'd3, 2'b10)}, 1'b1);
        do_upd(32'h0000_1044, 32'h9999, 1'b0, 1'b1, {64'h0, way(1, 27'h82, 32'h2000, 2'd2, 2'b10)}, 1'b1);
        // Miss not-taken: completion only
        do_upd(32'h0000_3008, 32'h7777, 1'b0, 1'b0, 128'h0, 1'b0);
        // Fill way1, then replace the LRU way0
        do_upd(32'h0000_1064, 32'h3000, 1'b1, 1'b1,
               {way(1, 27'h83, 32'h3000, 2'd2, 2'b00), way(1, 27'h82, 32'h2000, 2'd2, 2'b00)}, 1'b0);
        do_upd(32'h0000_1084, 32'h4000, 1'b1, 1'b1,
               {way(1, 27'h83, 32'h3000, 2'd2, 2'b00), way(1, 27'h84, 32'h4000, 2'd2, 2'b10)}, 1'b0);
        // Not-taken hit on way1
        do_upd(32'h0000_1064, 32'h5555, 1'b0, 1'b1,
               {way(1, 27'h83, 32'h3000, 2'd1, 2'b00), way(1, 27'h84, 32'h4000, 2'd2, 2'b00)}, 1'b1);

        // Flush and update together: flush wins
        wait_ready();
        c0         = cyc;
        flush      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h0000_1044;
        upd_target = 32'h6666;
        upd_taken  = 1'b1;
        for (int i = 0; i < 8; i++) wr_q.push_back('{idx: 3'(i), set: 128'h0, cyc: c0 + 1 + i});
        @(negedge clk);
        flush     = 1'b0;
        upd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("flush_ready_low", 128'(upd_ready), 128'(0));
            @(negedge clk);
        end
        check("flush_ready_back", 128'(upd_ready), 128'(1));

        // Flushed table misses again
        do_upd(32'h0000_1044, 32'h2000, 1'b1, 1'b1, {64'h0, way(1, 27'h82, 32'h2000, 2'd2, 2'b10)}, 1'b0);

        // Reset during LOOKUP aborts the update
        wait_ready();
        upd_pc     = 32'h0000_1044;
        upd_target = 32'h8888;
        upd_taken  = 1'b1;
        upd_valid  = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check_reset_outputs(1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", 128'(upd_ready), 128'(1));
        check("no_write_after_abort", 128'(write_enable), 128'(0));

        repeat (10) @(negedge clk);
        check("write_queue_drained", 128'(wr_q.size()), 128'(0));
        check("done_queue_drained", 128'(dn_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Write-side controller for the 8-set, 128-bit-per-set branch target buffer storage. It accepts resolved-branch updates from execute and reads the addressed set through the storage update port. It applies tag match, 2-bit counter, target and LRU rules, then writes the modified set back through the storage write port. It also provides a full-table flush sequencer.

Parameters:
NUM_SETS, 8, number of sets; index width is log2(NUM_SETS)=3.
SET_W, 128, set width; fixed as 2 ways x 64 bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
upd_valid  in  1  resolved-branch update request
upd_ready  out  1  controller can accept an update or flush
upd_pc  in  32  branch PC
upd_target  in  32  resolved target
upd_taken  in  1  resolved direction
flush  in  1  invalidate entire BTB
update_index  out  3  index to storage update port
update_set  in  128  set contents from storage update port (combinational)
write_index  out  3  storage write index
write_set  out  128  storage write data
write_enable  out  1  storage write strobe
upd_done  out  1  one-cycle pulse at completion of each accepted update
upd_hit  out  1  valid with upd_done: 1 = tag hit

Behaviour:
- Address split: index = pc[4:2], tag = pc[31:5] (27 b); pc[1:0] ignored.
- Set layout: way1 = [127:64], way0 = [63:0].
- Way layout: [63] valid, [62:36] tag, [35:4] target, [3:2] counter, [1:0] aux.
- Way0 aux[1] is the set LRU bit (value = victim way). Way0 aux[0] and way1 aux[1:0] are written 0.
- Reset: state IDLE, upd_ready=0 during rst and 1 the cycle after. write_enable=0, write_index=0, write_set=0, update_index=0, upd_done=0, upd_hit=0.
- Reset mid-operation aborts the operation with no write. Reset during flush leaves the remaining sets unflushed.
- FSM states: IDLE, LOOKUP, MODIFY, WRITE, FLUSH.
- IDLE: upd_ready=1.
  - flush=1 -> FLUSH with counter 0. flush wins over a simultaneous upd_valid; the update is not accepted.
  - Else upd_valid=1 -> capture pc/target/taken, drive update_index=pc[4:2] from the registered pc, go to LOOKUP.
- Outside IDLE: upd_ready=0; upd_valid and flush are ignored.
- LOOKUP: register update_set -> MODIFY.
- MODIFY: compute the new set.
  - hit_w = valid && tag match; if both ways hit, way0 wins.
  - Hit: counter saturating +1 if taken (max 3), saturating -1 if not (min 0). Target <- upd_target only if taken. LRU <- other way. Write required.
  - Miss and taken: victim = first invalid way (way0 priority), else the LRU way. Victim <- {valid 1, tag, target, counter 2'b10}. LRU <- other way. Write required.
  - Miss and not taken: no write; pulse upd_done (upd_hit=0) and return to IDLE.
  - Non-victim/non-hit way contents pass through unchanged, apart from the aux rule above.
- WRITE: write_enable=1 for exactly one cycle with registered write_index/write_set. upd_done=1, upd_hit as computed. -> IDLE.
- Latency: accept at cycle T, write_enable at T+3, upd_ready high again at T+4. Maximum throughput is one update per 4 cycles.
- FLUSH: each cycle write_enable=1, write_index=counter, write_set=0, counter+1. After index 7 -> IDLE. Flush takes exactly 8 cycles, with no upd_done.
- The storage's same-index write/read bypass handles read-after-write for fetch. This block never overlaps its own read and write.

Test Plan:
- Reset then upd_pc=0x0000_1044, target=0x2000, taken=1 on an empty set -> at T+3: write_index=1, way0 valid=1, tag=0x82, target=0x2000, ctr=2, LRU=1; upd_done=1, upd_hit=0.
- Repeat the same pc taken 3 times -> counter 2->3->3 (saturates); upd_hit=1 each time. Then not-taken -> ctr=2, target unchanged 0x2000.
- Miss not-taken (pc=0x0000_3008) -> no write_enable; upd_done at T+2 with upd_hit=0.
- Fill index 1 ways 0 and 1 with tags 0x82 and 0x83, then taken update with tag 0x84 -> way0 replaced (LRU=0), LRU becomes 1, way1 unchanged.
- Assert flush and upd_valid in the same IDLE cycle -> 8 writes, indices 0..7, write_set=0, upd_ready=0 for 8 cycles; the update is not accepted.
- Assert rst in the LOOKUP cycle -> no write_enable; all outputs at reset values next cycle; upd_ready=1 the cycle after rst drops.
